// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: multi-cycle binary-to-BCD converter using shift-and-add-3
// (double dabble). Each clock performs one shift, so wide operands do not
// build a long adder chain. An optional signed mode is supported, and the
// converter flags magnitudes that do not fit in DIGITS decimal digits.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     conversion request, honoured only while idle
//   in        binary operand (IN_W bits), captured with start
//   is_signed treat in as two's complement, captured with start
//   busy      conversion in progress
//   done      one-cycle pulse when bcd/sign/overflow are updated
//   bcd       result digits, digit 0 in [3:0]
//   sign      operand was negative (signed mode only)
//   overflow  magnitude >= 10^DIGITS; bcd holds magnitude mod 10^DIGITS
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// SHIFT | one add-3/shift step per cycle, IN_W steps in total
module bcd_seq_conv #(
  parameter int IN_W   = 15,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       in,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [IN_W-1:0] mag;
  logic [BW-1:0]   scr;
  logic [CW-1:0]   cnt;
  logic            sign_r;
  logic            ovf_acc;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scr_next;
  logic [IN_W-1:0] mag_next;
  logic            out_bit;

  // Add-3 correction on every digit, then one left shift of {scratch, mag}.
  always_comb begin
    adj = scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    out_bit  = adj[BW-1];
    scr_next = {adj[BW-2:0], mag[IN_W-1]};
    mag_next = {mag[IN_W-2:0], 1'b0};
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      scr      <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      ovf_acc  <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      sign     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Most negative operand negates to itself; read unsigned it is
            // exactly the wanted magnitude.
            if (is_signed && in[IN_W-1])
              mag <= ~in + 1'b1;
            else
              mag <= in;
            sign_r  <= is_signed & in[IN_W-1];
            scr     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(IN_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scr     <= scr_next;
          mag     <= mag_next;
          ovf_acc <= ovf_acc | out_bit;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd      <= scr_next;
            sign     <= sign_r;
            overflow <= ovf_acc | out_bit;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
module tb_bcd_seq_conv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // group A: IN_W=15 with DIGITS 5 (u0) and 4 (u1), shared stimulus
  logic        start_a, sgn_a;
  logic [14:0] in_a;
  logic        busy0, done0, sign0, ovf0;
  logic [19:0] bcd0;
  logic        busy1, done1, sign1, ovf1;
  logic [15:0] bcd1;

  // group B: IN_W=20 with DIGITS 6 (u2) and 7 (u3), shared stimulus
  logic        start_b, sgn_b;
  logic [19:0] in_b;
  logic        busy2, done2, sign2, ovf2;
  logic [23:0] bcd2;
  logic        busy3, done3, sign3, ovf3;
  logic [27:0] bcd3;

  bcd_seq_conv #(.IN_W(15), .DIGITS(5)) u0 (.clk(clk), .rst(rst), .start(start_a), .in(in_a),
    .is_signed(sgn_a), .busy(busy0), .done(done0), .bcd(bcd0), .sign(sign0), .overflow(ovf0));
  bcd_seq_conv #(.IN_W(15), .DIGITS(4)) u1 (.clk(clk), .rst(rst), .start(start_a), .in(in_a),
    .is_signed(sgn_a), .busy(busy1), .done(done1), .bcd(bcd1), .sign(sign1), .overflow(ovf1));
  bcd_seq_conv #(.IN_W(20), .DIGITS(6)) u2 (.clk(clk), .rst(rst), .start(start_b), .in(in_b),
    .is_signed(sgn_b), .busy(busy2), .done(done2), .bcd(bcd2), .sign(sign2), .overflow(ovf2));
  bcd_seq_conv #(.IN_W(20), .DIGITS(7)) u3 (.clk(clk), .rst(rst), .start(start_b), .in(in_b),
    .is_signed(sgn_b), .busy(busy3), .done(done3), .bcd(bcd3), .sign(sign3), .overflow(ovf3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand value.
  function automatic longint mag_of(input longint v, input int w, input bit s);
    if (s && ((v >> (w - 1)) & 1) == 1) return (longint'(1) << w) - v;
    return v;
  endfunction

  function automatic bit neg_of(input longint v, input int w, input bit s);
    return s && (((v >> (w - 1)) & 1) == 1);
  endfunction

  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    return p;
  endfunction

  function automatic longint ref_bcd(input longint m, input int d);
    longint r = 0;
    longint x = m % pow10(d);
    for (int i = 0; i < d; i++) begin
      r |= (x % 10) << (4 * i);
      x /= 10;
    end
    return r;
  endfunction

  task automatic start_a_op(input longint v, input bit s);
    in_a    = v[14:0];
    sgn_a   = s;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  // Waits for done of group A; pulse_at>0 injects an ignored start mid-run.
  task automatic wait_a(input string tag, input longint v, input bit s, input int pulse_at);
    int     lat  = 0;
    longint hold = bcd0;
    longint m    = mag_of(v, 15, s);
    for (int c = 1; c <= 40; c++) begin
      if (c == pulse_at) begin
        in_a    = ~in_a;
        start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done0) begin
        lat = c;
        break;
      end
      check({tag, "_hold"}, bcd0, hold);
    end
    check({tag, "_lat"},   lat, 15);
    check({tag, "_busy"},  busy0, 0);
    check({tag, "_bcd5"},  bcd0, ref_bcd(m, 5));
    check({tag, "_sign5"}, sign0, neg_of(v, 15, s));
    check({tag, "_ovf5"},  ovf0, m >= pow10(5));
    check({tag, "_done4"}, done1, 1);
    check({tag, "_bcd4"},  bcd1, ref_bcd(m, 4));
    check({tag, "_sign4"}, sign1, neg_of(v, 15, s));
    check({tag, "_ovf4"},  ovf1, m >= pow10(4));
  endtask

  task automatic run_b(input longint v, input bit s);
    int     lat = 0;
    longint m   = mag_of(v, 20, s);
    in_b    = v[19:0];
    sgn_b   = s;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = c;
        break;
      end
    end
    check("rnd_lat",   lat, 20);
    check("rnd_done7", done3, 1);
    check("rnd_bcd6",  bcd2, ref_bcd(m, 6));
    check("rnd_sign6", sign2, neg_of(v, 20, s));
    check("rnd_ovf6",  ovf2, m >= pow10(6));
    check("rnd_bcd7",  bcd3, ref_bcd(m, 7));
    check("rnd_sign7", sign3, neg_of(v, 20, s));
    check("rnd_ovf7",  ovf3, m >= pow10(7));
  endtask

  longint sweep[14] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9999, 10000, 12345, 27182, 31415, 32767};
  longint sv_val[4] = '{'h7FFF, 'h4000, 16383, 'h7FFF};
  bit     sv_sgn[4] = '{1, 1, 1, 0};

  initial begin
    int late_done;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    in_a = '0; in_b = '0; sgn_a = 1'b0; sgn_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_bcd",  bcd0, 0);
    check("rst_sign", sign0, 0);
    check("rst_ovf",  ovf0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // unsigned sweep, chained back-to-back: each start lands in the done cycle
    foreach (sweep[i]) begin
      start_a_op(sweep[i], 1'b0);
      check("acc_busy", busy0, 1);
      wait_a("sweep", sweep[i], 1'b0, 0);
    end

    foreach (sv_val[i]) begin
      start_a_op(sv_val[i], sv_sgn[i]);
      wait_a("signed", sv_val[i], sv_sgn[i], 0);
    end

    // start during a conversion with a different operand is ignored
    start_a_op(27182, 1'b0);
    wait_a("ignore", 27182, 1'b0, 5);

    // reset at cycle 7 of a conversion
    start_a_op(5432, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_bcd",  bcd0, 0);
    check("mid_rst_sign", sign0, 0);
    check("mid_rst_ovf",  ovf0, 0);
    late_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done0 || done1) late_done++;
    end
    check("mid_rst_no_done", late_done, 0);
    start_a_op(12345, 1'b0);
    wait_a("after_rst", 12345, 1'b0, 0);

    // random operands and modes at IN_W=20
    for (int n = 0; n < 1000; n++) begin
      longint v;
      v = longint'($urandom_range(0, (1 << 20) - 1));
      run_b(v, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seq_conv.md
# bcd_seq_conv

Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble). It replaces the fixed 15-bit combinational converter feeding the product display path of the serial-parallel multiplier, and extends it in three ways: configurable input width and digit count, an optional signed mode, and overflow detection. It uses one shift per clock with a start/busy/done handshake, so wide inputs do not create a long combinational adder chain.

## Interface
- IN_W, 15: binary input width in bits, minimum 2.
- DIGITS, 5: number of BCD output digits, minimum 1. Need not cover 2^IN_W−1; excess is flagged through `overflow`.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only while `busy`=0.
- in  in  IN_W  binary operand; sampled on the accepted `start` edge.
- is_signed  in  1  when 1, `in` is two's complement; sampled together with `in`.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; `bcd`, `sign` and `overflow` are valid from this cycle.
- bcd  out  4*DIGITS  result, digit 0 in [3:0]; holds its value until the next `done`.
- sign  out  1  1 when the signed operand was negative.
- overflow  out  1  1 when the magnitude is ≥ 10^DIGITS; `bcd` then holds the magnitude mod 10^DIGITS.

## Operation
- FSM states are IDLE and SHIFT. `busy` is 1 exactly when the state is SHIFT.
- **IDLE, start=1:** capture `in` and `is_signed`.
  - Magnitude register = −in (IN_W-bit two's negate) when `is_signed` & in[IN_W−1]; otherwise `in`.
  - The latched sign goes to an internal register (`sign_r`).
  - Clear the scratch BCD register (4*DIGITS bits) and the internal overflow accumulator. Set the bit counter to IN_W.
  - Go to SHIFT.
- **SHIFT, each cycle:**
  - For every scratch digit ≥5, add 3 (all digits in parallel).
  - Shift {scratch, magnitude} left by 1, taking the MSB of the magnitude into scratch bit 0.
  - The bit shifted out of scratch MSB is ORed into the overflow accumulator.
  - Decrement the counter.
- **Final SHIFT cycle (counter=1):** register `bcd` = shifted scratch, `sign` = latched sign, `overflow` = accumulator OR the final shifted-out bit, and `done` = 1. Go to IDLE.
- Most negative input with IN_W=15 is −16384. It negates to magnitude 16384 (unsigned reinterpretation is correct), with `sign`=1.
- `sign` is always 0 when `is_signed`=0.
- `start` while `busy`=1 is ignored. `in` changes during a conversion have no effect.
- Reset is synchronous, active-high, and may arrive mid-conversion:
  - State → IDLE, all registers cleared.
  - `busy`=0, `done`=0, `bcd`=0, `sign`=0, `overflow`=0.
  - The aborted conversion never produces `done`.

## Timing
- `start` is accepted at edge E0. `busy` is 1 from E0 to E_IN_W.
- `done`=1 for exactly the cycle after E_IN_W. Latency is IN_W cycles from the accepted `start` to `done`.
- `done` and `busy`=0 occur in the same cycle. A `start` in that cycle is accepted, giving back-to-back throughput of one result per IN_W cycles.
- Outputs are registered with no combinational path from the inputs.
- `bcd`/`sign`/`overflow` change only on the `done` edge or on reset.

## Test plan
- Defaults IN_W=15, DIGITS=5, unsigned sweep: apply 0, 1, 9, 10, 99, 100, 999, 1000, 9999, 10000, 12345, 27182, 31415, 32767.
  - Required per value: `bcd` equals the decimal digits (e.g. 32767 → 0x32767), `done` exactly 15 cycles after `start`, `overflow`=0, `sign`=0.
- Signed mode (defaults): −1 → bcd 0x00001, sign 1; −16384 → 0x16384, sign 1; 16383 → 0x16383, sign 0.
  - `is_signed`=0 with in=0x7FFF → 0x32767, sign 0.
- Overflow with IN_W=15, DIGITS=4: 9999 → 0x9999, overflow 0; 10000 → 0x0000, overflow 1; 32767 → 0x2767, overflow 1.
- Handshake:
  - `start` pulsed again mid-conversion with a different `in` is ignored; the original result appears at cycle 15.
  - `start` asserted in the `done` cycle gives the second `done` exactly 15 cycles later.
  - `bcd` remains stable between `done` pulses.
- Reset: assert `rst` for 1 cycle at cycle 7 of a conversion.
  - All outputs are 0 on the next cycle and no `done` follows.
  - A new conversion of 12345 then completes correctly in 15 cycles.
- Random: 1000 random operands and modes, IN_W=20, DIGITS=6 and 7. Compare against a reference model of the digits, sign and overflow, and check latency is exactly 20 cycles.
